// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS bus memory responder.
package mips_bus_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  byteen_t;

  // Lane i of the result comes from new_w when be[i] is set, otherwise from old_w.
  function automatic word_t merge_bytes(word_t old_w, word_t new_w, byteen_t be);
    word_t result;
    result = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) result[8*i +: 8] = new_w[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mips_bus_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to jitter bus wait states.
module mips_bus_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/mips_bus_ram.sv
// Avalon-style memory responder for mips_cpu_bus with programmable wait states.
// Define MIPS_RAM_RANDOM_WAIT_EN to add LFSR-driven extra stall cycles.
module mips_bus_ram
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = "",
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address,
  input  logic          read,
  input  logic          write,
  output logic          waitrequest,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  output logic [31:0]   readdata,
  output logic          err,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  word_t       mem_q [DEPTH_WORDS];
  logic [3:0]  cnt_q, cnt_d;
  word_t       readdata_q, readdata_d;
  logic        err_q, err_d;

  logic        request, accept, baseStall, extraStall, inWindow;
  logic [29:0] wordOff;
  logic [AW-1:0] index;

  assign request  = read | write;
  assign wordOff  = address[31:2] - BASE_ADDR[31:2];
  assign index    = wordOff[AW-1:0];
  assign inWindow = (address >= BASE_ADDR) && (wordOff < 30'(DEPTH_WORDS));

  // Reset forces the stall low immediately so nothing is accepted while it is held.
  assign baseStall   = (cnt_q != WS);
  assign waitrequest = request & ~reset & (baseStall | extraStall);
  assign accept      = request & ~reset & ~waitrequest;

`ifdef MIPS_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  logic [1:0]  extra_q, extra_d;

  mips_bus_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign extraStall = lfsr[0] && (extra_q != 2'd3);

  always_comb begin
    extra_d = extra_q;
    if (!request || accept)              extra_d = 2'd0;
    else if (waitrequest && !baseStall)  extra_d = extra_q + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) extra_q <= 2'd0;
    else       extra_q <= extra_d;
  end
`else
  assign extraStall = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (!request || accept)          cnt_d = 4'd0;
    else if (waitrequest && baseStall) cnt_d = cnt_q + 4'd1;
  end

  // A simultaneous read+write is treated as a write and flagged; address 0 reads are halt fetches.
  always_comb begin
    readdata_d = readdata_q;
    err_d      = err_q;
    if (accept) begin
      if (write) begin
        if (!inWindow || read) err_d = 1'b1;
      end else if (inWindow) begin
        readdata_d = mem_q[index];
      end else begin
        readdata_d = '0;
        if (address != 32'h0) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      readdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && write && inWindow)
      mem_q[index] <= merge_bytes(mem_q[index], writedata, byteenable);
  end

  assign readdata = readdata_q;
  assign err      = err_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_mips_bus_ram.sv
// Directed plus randomized bench for mips_bus_ram against a word-array reference model.
module tb_mips_bus_ram;

  localparam int          WS    = 2;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read, write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        err;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] modelMem [DEPTH];
  logic [31:0] expRd;
  logic        expErr;

  mips_bus_ram #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .INIT_FILE   ("")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: plain byte-address arithmetic over a word array.
  task automatic modelAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
    bit          inWin;
    int          idx;
    logic [31:0] mask;
    inWin = (addr >= BASE) && (((addr - BASE) / 4) < DEPTH);
    idx   = inWin ? int'((addr - BASE) / 4) : 0;
    mask  = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    if (wr) begin
      if (inWin) modelMem[idx] = (modelMem[idx] & ~mask) | (data & mask);
      if (!inWin || rd) expErr = 1'b1;
    end else if (rd) begin
      if (inWin) expRd = modelMem[idx];
      else begin
        expRd = 32'h0;
        if (addr != 32'h0) expErr = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
    int stalls;
    @(negedge clk);
    address = addr; read = rd; write = wr; writedata = data; byteenable = be;
    stalls = 0;
    #1;
    while (waitrequest === 1'b1 && stalls < 40) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    modelAccess(rd, wr, addr, data, be);
`ifdef MIPS_RAM_RANDOM_WAIT_EN
    checkOutput("stalls_in_range", 32'(stalls >= WS && stalls <= WS + 3), 32'd1);
`else
    checkOutput("stalls", 32'(stalls), 32'(WS));
`endif
    @(negedge clk);
    checkOutput("readdata", readdata, expRd);
    checkOutput("err", 32'(err), 32'(expErr));
  endtask

  task automatic checkDbg(input int idx);
    dbg_addr = 6'(idx);
    #1;
    checkOutput("dbg_data", dbg_data, modelMem[idx]);
  endtask

  initial begin
    logic [31:0] w, a, saved;
    int          sel, idx;

    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; dbg_addr = '0;
    expRd = '0; expErr = 1'b0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_waitrequest", 32'(waitrequest), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

    // Stalled read of a known instruction word
    applyStimulus(1'b0, 1'b1, 32'hBFC00004, 32'h8D090030, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0);
    checkOutput("read_instr", readdata, 32'h8D090030);

    // Byte-lane merge and empty byteenable
    applyStimulus(1'b0, 1'b1, 32'hBFC00030, 32'hAABBCCDD, 4'hF);
    applyStimulus(1'b0, 1'b1, 32'hBFC00030, 32'h00000011, 4'h1);
    checkDbg(12);
    checkOutput("merge_word", dbg_data, 32'hAABBCC11);
    applyStimulus(1'b0, 1'b1, 32'hBFC00030, 32'h12345678, 4'h0);
    checkDbg(12);
    checkOutput("be0_word", dbg_data, 32'hAABBCC11);

    // Halt fetch, then read+write collision
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 32'hBFC00008, 32'h5, 4'hF);
    checkDbg(2);
    checkOutput("collision_word", dbg_data, 32'h5);
    checkOutput("collision_readdata", readdata, 32'h8D090030);

    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    expRd = '0; expErr = 1'b0;
    checkOutput("rst2_err", 32'(err), 32'h0);
    checkOutput("rst2_readdata", readdata, 32'h0);
    checkDbg(12);

    // Out-of-window read raises a sticky error
    applyStimulus(1'b1, 1'b0, 32'h00001000, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0);
    checkOutput("err_sticky", 32'(err), 32'h1);

    // Withdraw a read after one stall cycle
    saved = readdata;
    @(negedge clk);
    address = 32'hBFC00010; read = 1'b1;
    #1;
    checkOutput("drop_wait_hi", 32'(waitrequest), 32'h1);
    @(negedge clk);
    read = 1'b0;
    #1;
    checkOutput("drop_wait_lo", 32'(waitrequest), 32'h0);
    @(negedge clk);
    checkOutput("drop_readdata", readdata, saved);
    applyStimulus(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0);

    // Reset asserted while a write is stalled
    @(negedge clk);
    address = 32'hBFC00014; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
    #1;
    checkOutput("rst_stall_wait_hi", 32'(waitrequest), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_stall_wait_lo", 32'(waitrequest), 32'h0);
    @(negedge clk);
    reset = 1'b0; write = 1'b0;
    expRd = '0; expErr = 1'b0;
    checkOutput("rst_stall_readdata", readdata, 32'h0);
    checkOutput("rst_stall_err", 32'(err), 32'h0);
    checkDbg(5);

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, DEPTH - 1);
      if (sel < 8)       a = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
      else if (sel == 8) a = 32'h0;
      else               a = $urandom;
      sel = $urandom_range(0, 9);
      w = $urandom;
      if (sel < 5)      applyStimulus(1'b1, 1'b0, a, w, 4'($urandom));
      else if (sel < 9) applyStimulus(1'b0, 1'b1, a, w, 4'($urandom));
      else              applyStimulus(1'b1, 1'b1, a, w, 4'($urandom));
      checkDbg($urandom_range(0, DEPTH - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
